// File: rtl/usr_shift_ctrl.sv
// Sequencer for an 8-bit universal shift register: load a byte, shift it N times, capture q.
// Optional rotate mode (cmd_rot port) is enabled by defining USR_CTRL_ROTATE_EN.
module usr_shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [3:0]       cmd_count,
  input  logic             cmd_fill,
`ifdef USR_CTRL_ROTATE_EN
  input  logic             cmd_rot,
`endif
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] data_reg;
  logic             dir_reg;
  logic             fill_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic             shift_in;
  logic             accept;

  assign accept = (state_reg == IDLE) && cmd_valid;

`ifdef USR_CTRL_ROTATE_EN
  logic rot_reg;

  // Rotate feeds back the bit that falls off the far end of the register.
  assign shift_in = rot_reg ? (dir_reg ? usr_q[0] : usr_q[WIDTH-1]) : fill_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rot_reg <= 1'b0;
    end else if (accept) begin
      rot_reg <= cmd_rot;
    end
  end
`else
  assign shift_in = fill_reg;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      data_reg   <= '0;
      dir_reg    <= 1'b0;
      fill_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == CAPTURE);
      if (state_reg == CAPTURE) begin
        result_reg <= usr_q;
      end
      if (accept) begin
        data_reg <= cmd_data;
        dir_reg  <= cmd_dir;
        fill_reg <= cmd_fill;
        cnt_reg  <= (cmd_count > 4'd8) ? 4'd8 : cmd_count;
      end else if (state_reg == SHIFT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    usr_ctrl   = 2'b00;
    usr_d      = '0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) state_next = LOAD;
      end
      LOAD: begin
        usr_ctrl   = 2'b11;
        usr_d      = data_reg;
        state_next = (cnt_reg != 4'd0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        if (dir_reg) begin
          usr_ctrl         = 2'b10;
          usr_d[WIDTH-1]   = shift_in;
        end else begin
          usr_ctrl = 2'b01;
          usr_d[0] = shift_in;
        end
        // cnt_reg still holds this cycle's shift, so 1 means it is the last one.
        if (cnt_reg == 4'd1) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl with a behavioural universal shift register on usr_ctrl/usr_d/usr_q.
// Rotate test runs only when USR_CTRL_ROTATE_EN is defined.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic       cmd_fill = 1'b0;
`ifdef USR_CTRL_ROTATE_EN
  logic       cmd_rot = 1'b0;
`endif
  logic [1:0] usr_ctrl;
  logic [7:0] usr_d;
  logic [7:0] usr_q;
  logic       busy;
  logic       done;
  logic [7:0] result;

  logic [7:0] sr = 8'h00;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
`ifdef USR_CTRL_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .usr_ctrl  (usr_ctrl),
    .usr_d     (usr_d),
    .usr_q     (usr_q),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Universal shift register being controlled.
  always @(posedge clk) begin
    case (usr_ctrl)
      2'b01:   sr <= {sr[6:0], usr_d[0]};
      2'b10:   sr <= {usr_d[7], sr[7:1]};
      2'b11:   sr <= usr_d;
      default: sr <= sr;
    endcase
  end
  assign usr_q = sr;

  // Called at a negedge while idle; returns just after the acceptance edge.
  task automatic start_cmd(input logic [7:0] data, input logic dir, input logic [3:0] count,
                           input logic fill, input logic rot, input bit keep_valid);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_count = count;
    cmd_fill  = fill;
`ifdef USR_CTRL_ROTATE_EN
    cmd_rot   = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until done; cyc stays -1 if the bound expires.
  task automatic wait_done(input logic [1:0] sctrl, output int cyc, output int shifts,
                           output logic [7:0] sd);
    cyc = -1;
    shifts = 0;
    sd = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (usr_ctrl === sctrl) begin
        shifts++;
        sd = usr_d;
      end
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = 8'hFF;
    cmd_count = 4'd3;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      checks++;
      if (usr_ctrl !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00", usr_ctrl); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++;
    if (usr_d !== 8'h00) begin failures++; $display("FAIL reset_usr_d got=%h exp=00", usr_d); end
    $display("txn reset: ready=%b ctrl=%b", cmd_ready, usr_ctrl);
  endtask

  task automatic test_left();
    start_cmd(8'hD3, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (usr_ctrl !== 2'b11 || usr_d !== 8'hD3) begin
      failures++; $display("FAIL left_load got=%b/%h exp=11/d3", usr_ctrl, usr_d);
    end
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL left_busy got=%b/%b exp=1/0", busy, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (usr_ctrl !== 2'b01 || usr_d !== 8'h00) begin
      failures++; $display("FAIL left_shift got=%b/%h exp=01/00", usr_ctrl, usr_d);
    end
    @(negedge clk);
    checks++;
    if (usr_ctrl !== 2'b00 || done !== 1'b0) begin
      failures++; $display("FAIL left_capture got=%b/%b exp=00/0", usr_ctrl, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'hA6) begin
      failures++; $display("FAIL left_done got=%b/%h exp=1/a6", done, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL left_pulse got=%b exp=0", done); end
    $display("txn left: data=d3 count=1 result=%h", result);
  endtask

  task automatic test_right();
    int cyc, shifts;
    logic [7:0] sd;
    start_cmd(8'hD3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    wait_done(2'b10, cyc, shifts, sd);
    checks++;
    if (cyc !== 6) begin failures++; $display("FAIL right_latency got=%0d exp=6", cyc); end
    checks++;
    if (shifts !== 3) begin failures++; $display("FAIL right_shifts got=%0d exp=3", shifts); end
    checks++;
    if (sd !== 8'h80) begin failures++; $display("FAIL right_usr_d got=%h exp=80", sd); end
    checks++;
    if (result !== 8'hFA) begin failures++; $display("FAIL right_result got=%h exp=fa", result); end
    $display("txn right: data=d3 count=3 result=%h cycles=%0d", result, cyc);
    @(negedge clk);
    start_cmd(8'hD3, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    wait_done(2'b10, cyc, shifts, sd);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL zero_latency got=%0d exp=3", cyc); end
    checks++;
    if (shifts !== 0) begin failures++; $display("FAIL zero_shifts got=%0d exp=0", shifts); end
    checks++;
    if (result !== 8'hD3) begin failures++; $display("FAIL zero_result got=%h exp=d3", result); end
    $display("txn right: data=d3 count=0 result=%h cycles=%0d", result, cyc);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, shifts;
    logic [7:0] sd;
    start_cmd(8'h00, 1'b0, 4'd12, 1'b1, 1'b0, 1'b1);
    // Second command waits on the inputs while the first runs.
    cmd_data  = 8'h5A;
    cmd_dir   = 1'b1;
    cmd_count = 4'd0;
    cmd_fill  = 1'b0;
    wait_done(2'b01, cyc, shifts, sd);
    checks++;
    if (shifts !== 8) begin failures++; $display("FAIL sat_shifts got=%0d exp=8", shifts); end
    checks++;
    if (cyc !== 11) begin failures++; $display("FAIL sat_latency got=%0d exp=11", cyc); end
    checks++;
    if (result !== 8'hFF) begin failures++; $display("FAIL sat_result got=%h exp=ff", result); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
    $display("txn saturate: data=00 count=12 result=%h cycles=%0d", result, cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (usr_ctrl !== 2'b11 || usr_d !== 8'h5A) begin
      failures++; $display("FAIL b2b_load got=%b/%h exp=11/5a", usr_ctrl, usr_d);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'h5A) begin
      failures++; $display("FAIL b2b_done got=%b/%h exp=1/5a", done, result);
    end
    $display("txn back_to_back: data=5a count=0 result=%h", result);
    @(negedge clk);
  endtask

  task automatic test_abort();
    int pulses;
    start_cmd(8'hD3, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (usr_ctrl !== 2'b01) begin failures++; $display("FAIL abort_in_shift got=%b exp=01", usr_ctrl); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (usr_ctrl !== 2'b00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL abort_idle got=%b/%b/%b exp=00/0/1", usr_ctrl, busy, cmd_ready);
    end
    checks++;
    if (result !== 8'h00) begin failures++; $display("FAIL abort_result got=%h exp=00", result); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", pulses); end
    $display("txn abort: result=%h done_pulses=%0d", result, pulses);
  endtask

`ifdef USR_CTRL_ROTATE_EN
  task automatic test_rotate();
    int cyc, shifts;
    logic [7:0] sd;
    start_cmd(8'h81, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    wait_done(2'b01, cyc, shifts, sd);
    checks++;
    if (result !== 8'h03) begin failures++; $display("FAIL rotate_result got=%h exp=03", result); end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL rotate_latency got=%0d exp=4", cyc); end
    $display("txn rotate: data=81 count=1 result=%h", result);
    cmd_rot = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_left();
    test_right();
    test_back_to_back();
`ifdef USR_CTRL_ROTATE_EN
    test_rotate();
`endif
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
